// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file with pending scoreboard.
// The optional sweep preset is enabled with the REGFILE_PRESET_EN macro (see regfile_sb).
package regfile_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam state_t RST_STATE = INIT;
    localparam logic   RST_READY = 1'b0;

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: set at issue, cleared at writeback, set wins on a tie.
// Lookups hide a pending bit that the same-cycle writeback is about to resolve.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              pend_1,
    output logic              pend_2
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en && (clr_addr != '0)) begin
            pend_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so a newer producer keeps the register pending.
        if (set_en && (set_addr != '0)) begin
            pend_d[set_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_1 = pend_q[rd_addr_1] & ~(byp_en && (byp_addr == rd_addr_1));
    assign pend_2 = pend_q[rd_addr_2] & ~(byp_en && (byp_addr == rd_addr_2));

endmodule

// File: rtl/regfile_sb.sv
// MIPS register file: 2 combinational reads, 1 write, r0 hardwired, write-through bypass,
// pending scoreboard and post-reset clear sweep. REGFILE_PRESET_EN: sweep preloads PRESET_IDX.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                PRESET_IDX = 13,
    parameter logic [DATA_W-1:0] PRESET_VAL = DATA_W'(3)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              pend_1,
    output logic              pend_2,
    output logic              ready
);

    localparam int                NUM_REGS    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] PRESET_ADDR = ADDR_W'(PRESET_IDX);
`ifdef REGFILE_PRESET_EN
    localparam logic              PRESET_EN   = 1'b1;
`else
    localparam logic              PRESET_EN   = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Handshake: ready=1 means RegWrite and sb_set are accepted at the next rising edge;
    // while ready=0 (sweep running) both are ignored and all read outputs are held at 0.
    assign ready = (state_q == READY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Single write port shared by the sweep and normal writeback.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] sweep_val;

    assign sweep_val = (PRESET_EN && (ptr_q == PRESET_ADDR)) ? PRESET_VAL : '0;
    assign wr_en     = ready ? (RegWrite && (write_addr != '0)) : 1'b1;
    assign wr_addr   = ready ? write_addr : ptr_q;
    assign wr_data   = ready ? write_data : sweep_val;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    logic byp_1, byp_2;

    assign byp_1 = RegWrite && (write_addr == read_addr_1);
    assign byp_2 = RegWrite && (write_addr == read_addr_2);

    assign data_out_1 = (!ready || (read_addr_1 == '0)) ? '0 :
                        byp_1 ? write_data : regs[read_addr_1];
    assign data_out_2 = (!ready || (read_addr_2 == '0)) ? '0 :
                        byp_2 ? write_data : regs[read_addr_2];

    logic sb_pend_1, sb_pend_2;

    regfile_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (ready && sb_set),
        .set_addr (sb_set_addr),
        .clr_en   (ready && RegWrite),
        .clr_addr (write_addr),
        .byp_en   (RegWrite),
        .byp_addr (write_addr),
        .rd_addr_1(read_addr_1),
        .rd_addr_2(read_addr_2),
        .pend_1   (sb_pend_1),
        .pend_2   (sb_pend_2)
    );

    assign pend_1 = ready & sb_pend_1;
    assign pend_2 = ready & sb_pend_2;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations are queued by the driver and checked by a monitor.
// Expected sweep values follow REGFILE_PRESET_EN when it is defined for the build.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int W  = 3 + 2 * 32;

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr_1;
    logic [4:0]  read_addr_2;
    logic [31:0] data_out_1;
    logic [31:0] data_out_2;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic        pend_1;
    logic        pend_2;
    logic        ready;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .RegWrite   (RegWrite),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr_1(read_addr_1),
        .read_addr_2(read_addr_2),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .sb_set     (sb_set),
        .sb_set_addr(sb_set_addr),
        .pend_1     (pend_1),
        .pend_2     (pend_2),
        .ready      (ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    string        exp_nm;

    // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_v  = exp_q.pop_front();
            exp_nm = name_q.pop_front();
            act_v  = {ready, pend_1, pend_2, data_out_1, data_out_2};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got rdy=%b p1=%b p2=%b d1=%h d2=%h, required rdy=%b p1=%b p2=%b d1=%h d2=%h",
                         exp_nm, act_v[66], act_v[65], act_v[64], act_v[63:32], act_v[31:0],
                         exp_v[66], exp_v[65], exp_v[64], exp_v[63:32], exp_v[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic rdy, input logic p1, input logic p2,
                              input logic [31:0] d1, input logic [31:0] d2);
        exp_q.push_back({rdy, p1, p2, d1, d2});
        name_q.push_back(nm);
    endtask

    task automatic idle();
        RegWrite    = 1'b0;
        write_addr  = '0;
        write_data  = '0;
        sb_set      = 1'b0;
        sb_set_addr = '0;
        read_addr_1 = '0;
        read_addr_2 = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite   = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_addr_1 = a1;
        read_addr_2 = a2;
    endtask

    task automatic issue(input logic [4:0] a);
        sb_set      = 1'b1;
        sb_set_addr = a;
    endtask

    function automatic logic [31:0] swept(input int a);
`ifdef REGFILE_PRESET_EN
        if (a == 13) return 32'd3;
`endif
        return 32'd0;
    endfunction

    // Release reset and run the full sweep, checking ready just before and at completion.
    task automatic sweep_after_release(input string tag);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 31) expect_out({tag, "_ready_lo_31"}, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == 32) expect_out({tag, "_ready_hi_32"}, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        tick();
        wr(5'd3, 32'hCAFE0003);
        rd(5'd3, 5'd3);
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        idle();
        rst = 1'b0;

        // reset pulse in the middle of the sweep
        for (int k = 1; k <= 10; k++) tick();
        rst = 1'b1;
        expect_out("mid_sweep_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;

        // full sweep with ignored write/issue while in INIT
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 20) expect_out("sweep_ready_lo_20", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == 25) begin
                wr(5'd4, 32'h11111111);
                issue(5'd4);
                rd(5'd4, 5'd4);
                expect_out("init_forced_zero", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (k == 26) idle();
            if (k == 31) expect_out("sweep_ready_lo_31", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == 32) expect_out("sweep_ready_hi_32", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end

        // writes/issues during INIT left no trace
        rd(5'd4, 5'd4);
        expect_out("init_write_dropped", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // every register holds its sweep value
        for (int i = 1; i <= 31; i++) begin
            rd(5'(i), 5'(32 - i));
            expect_out($sformatf("sweep_val_r%0d", i), 1'b1, 1'b0, 1'b0, swept(i), swept(32 - i));
            tick();
        end

        // r0 is hardwired
        idle();
        wr(5'd0, 32'hDEADBEEF);
        rd(5'd0, 5'd0);
        expect_out("r0_write_bypass", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        idle();
        rd(5'd0, 5'd0);
        expect_out("r0_after_write", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        wr(5'd7, 32'h12345678);
        tick();
        idle();
        rd(5'd7, 5'd7);
        expect_out("r7_readback", 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h12345678);
        tick();

        // same-cycle bypass on both ports
        idle();
        wr(5'd9, 32'hA5A5A5A5);
        rd(5'd9, 5'd9);
        expect_out("r9_bypass", 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tick();
        idle();
        rd(5'd9, 5'd7);
        expect_out("r9_stored", 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h12345678);
        tick();

        // scoreboard set, then cleared by writeback
        idle();
        issue(5'd5);
        rd(5'd5, 5'd6);
        expect_out("sb_set_r5_same_cycle", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        idle();
        rd(5'd5, 5'd6);
        expect_out("sb_r5_pending", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        wr(5'd5, 32'h00000055);
        rd(5'd5, 5'd5);
        expect_out("sb_r5_wb_masked", 1'b1, 1'b0, 1'b0, 32'h55, 32'h55);
        tick();
        idle();
        rd(5'd5, 5'd5);
        expect_out("sb_r5_cleared", 1'b1, 1'b0, 1'b0, 32'h55, 32'h55);
        tick();

        // set and clear on the same register: set wins; r0 never pending
        idle();
        issue(5'd6);
        wr(5'd6, 32'h00000066);
        rd(5'd6, 5'd0);
        expect_out("sb_r6_set_and_wb", 1'b1, 1'b0, 1'b0, 32'h66, 32'h0);
        tick();
        idle();
        issue(5'd0);
        rd(5'd6, 5'd0);
        expect_out("sb_r6_set_wins", 1'b1, 1'b1, 1'b0, 32'h66, 32'h0);
        tick();
        idle();
        issue(5'd6);
        rd(5'd6, 5'd0);
        expect_out("sb_r0_never_pending", 1'b1, 1'b1, 1'b0, 32'h66, 32'h0);
        tick();
        idle();
        rd(5'd0, 5'd6);
        expect_out("sb_r6_reset_stays", 1'b1, 1'b0, 1'b1, 32'h0, 32'h66);
        tick();
        wr(5'd6, 32'h00000067);
        tick();
        idle();
        rd(5'd6, 5'd6);
        expect_out("sb_r6_single_clear", 1'b1, 1'b0, 1'b0, 32'h67, 32'h67);
        tick();

        // reset from READY clears pending bits and re-sweeps the array
        idle();
        issue(5'd12);
        tick();
        idle();
        rd(5'd12, 5'd7);
        expect_out("pre_rst_r12_pending", 1'b1, 1'b1, 1'b0, 32'h0, 32'h12345678);
        tick();
        rst = 1'b1;
        expect_out("ready_rst_outputs", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        sweep_after_release("resweep");
        rd(5'd7, 5'd12);
        expect_out("resweep_r7_r12", 1'b1, 1'b0, 1'b0, swept(7), swept(12));
        tick();
        rd(5'd13, 5'd9);
        expect_out("resweep_r13_r9", 1'b1, 1'b0, 1'b0, swept(13), swept(9));
        tick();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
